seq_chunk_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor. Each cycle it processes one CHUNK-bit slice, LSB first, and holds the carry in a register between slices.
- Parametrised successor of the 1-bit full-adder cell. Adds carry-in, subtract mode, signed-overflow flag and valid/ready handshakes on input and output.
- Used in the arithmetic datapath wherever a narrow, area-cheap adder with multi-cycle latency is acceptable.

---
 rtl/adder_pkg.sv | 18 +
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/chunk_add.sv | 12 +
 rtl/seq_chunk_adder.sv | 126 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the sequential chunked adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf, busy
    );
endinterface

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple adder slice: multi-bit form of a full-adder cell.
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice per cycle, LSB first,
// with the inter-slice carry held in a register.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_chunk_adder_if.slave bus
);
    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int CW  = cnt_w(NCH);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             co_r;
    logic             ovf_r;

    int               base_s;
    logic [CHUNK-1:0] a_sl_s;
    logic [CHUNK-1:0] b_sl_s;
    logic [CHUNK-1:0] s_s;
    logic             c_next_s;
    logic             last_s;
    logic             accept_s;

    // Select the active slice of the held operands.
    always_comb begin
        base_s = int'(cnt_r) * CHUNK;
        a_sl_s = a_r[base_s +: CHUNK];
        b_sl_s = b_r[base_s +: CHUNK];
        last_s = (cnt_r == CW'(NCH - 1));
    end

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a  (a_sl_s),
        .b  (b_sl_s),
        .ci (carry_r),
        .s  (s_s),
        .co (c_next_s)
    );

    assign accept_s = (state_r == IDLE) && bus.in_valid;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture (subtract folds into ~b and ~ci) and per-slice datapath update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? ~bus.ci : bus.ci;
            cnt_r   <= '0;
        end else if (state_r == RUN) begin
            sum_r[base_s +: CHUNK] <= s_s;
            carry_r <= c_next_s;
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
                co_r  <= c_next_s;
                ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_s[CHUNK-1] != a_r[WIDTH-1]);
            end
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.sum       = sum_r;
    assign bus.co        = co_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed scoreboard bench for seq_chunk_adder (CHUNK=8 and CHUNK=32 instances).
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(32)) bus  ();
    seq_chunk_adder_if #(.WIDTH(32)) bus1 ();

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  dut  (.clk(clk), .rst(rst), .bus(bus));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub);
        exp_t        e;
        logic [31:0] be;
        logic        ce;
        logic [32:0] full;
        be    = sub ? ~b : b;
        ce    = sub ? ~ci : ci;
        full  = {1'b0, a} + {1'b0, be} + {32'd0, ce};
        e.sum = full[31:0];
        e.co  = full[32];
        e.ovf = (a[31] == be[31]) && (full[31] != a[31]);
        return e;
    endfunction

    // Waits for in_ready, presents one operation for one edge; returns at the negedge after accept.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sub, input bit push);
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub;
        bus.in_valid = 1'b1;
        if (push) sb.push_back(model(a, b, ci, sub));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        check("in_ready_in_run", {63'd0, bus.in_ready}, 64'd0);
    endtask

    // Waits for the result, checks latency and value, optionally holds it, then releases.
    task automatic collect(input int hold);
        int   n = 0;
        exp_t e;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'd4);
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check("sum", {32'd0, bus.sum}, {32'd0, e.sum});
        check("co",  {63'd0, bus.co},  {63'd0, e.co});
        check("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a = $urandom; bus.b = $urandom; bus.ci = 1'b1; bus.sub = 1'b0;
            @(negedge clk);
            check("hold_valid",    {63'd0, bus.out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, bus.in_ready},  64'd0);
            check("hold_sum", {32'd0, bus.sum}, {32'd0, e.sum});
            check("hold_co",  {63'd0, bus.co},  {63'd0, e.co});
            check("hold_ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_valid", {63'd0, bus.out_valid}, 64'd0);
        check("release_ready", {63'd0, bus.in_ready},  64'd1);
        check("idle_sum_held", {32'd0, bus.sum}, {32'd0, e.sum});
    endtask

    initial begin
        exp_t e1;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_sum", {32'd0, bus.sum}, 64'd0);
        check("rst_co",  {63'd0, bus.co},  64'd0);
        check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1); collect(0);
        start_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);                 collect(0);
        start_op(32'd7, 32'd5, 1'b0, 1'b1, 1'b1);                 collect(0);
        start_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);         collect(0);
        start_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1);         collect(0);
        start_op(32'd10, 32'd3, 1'b1, 1'b1, 1'b1);                collect(0);
        start_op(32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0, 1'b1); collect(0);
        start_op(32'h00FF_00FF, 32'h0001_FF01, 1'b0, 1'b0, 1'b1); collect(3);
        start_op(32'h1000_0000, 32'h2000_0001, 1'b0, 1'b1, 1'b1); collect(0);

        // Abort mid-run at cnt==2: reset must drop everything immediately.
        start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("abort_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("abort_sum", {32'd0, bus.sum}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_result", {63'd0, bus.out_valid}, 64'd0);
        end
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1); collect(0);
        check("abort_fresh_model", 64'(model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0).sum), 64'h2345_6789);

        // Single-slice instance: result one edge after accept.
        bus1.a = 32'hFFFF_FFFF; bus1.b = 32'hFFFF_FFFF; bus1.ci = 1'b1; bus1.sub = 1'b0;
        bus1.in_valid = 1'b1;
        e1 = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("n1_in_ready", {63'd0, bus1.in_ready}, 64'd0);
        @(negedge clk);
        check("n1_out_valid", {63'd0, bus1.out_valid}, 64'd1);
        check("n1_sum", {32'd0, bus1.sum}, {32'd0, e1.sum});
        check("n1_co",  {63'd0, bus1.co},  {63'd0, e1.co});
        check("n1_ovf", {63'd0, bus1.ovf}, {63'd0, e1.ovf});
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("n1_release", {63'd0, bus1.out_valid}, 64'd0);
        bus1.a = 32'h7FFF_FFFF; bus1.b = 32'h0000_0001; bus1.ci = 1'b0; bus1.sub = 1'b0;
        bus1.in_valid = 1'b1;
        e1 = model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("n1b_out_valid", {63'd0, bus1.out_valid}, 64'd1);
        check("n1b_sum", {32'd0, bus1.sum}, {32'd0, e1.sum});
        check("n1b_ovf", {63'd0, bus1.ovf}, {63'd0, e1.ovf});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
